// File: rtl/audio_pkg.sv
// Shared encodings for the audio output mux: source selects, switch sequencer states
// and the default gain word width.
package audio_pkg;

    localparam int GAIN_W_DEF = 16;

    localparam logic [1:0] SRC_I2S    = 2'b00;
    localparam logic [1:0] SRC_INTERP = 2'b01;
    localparam logic [1:0] SRC_SINE   = 2'b10;
    localparam logic [1:0] SRC_EQ     = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FADE_OUT,
        FLUSH,
        SETTLE,
        FADE_IN
    } state_t;

endpackage

// File: rtl/audio_src_switch_ctrl_gain_ramp.sv
// Saturating gain register for the source-switch sequencer: steps up or down by STEP,
// clamped to [0, unity], and flags both end points.
module gain_ramp #(
    parameter int GAIN_W = 16,
    parameter int STEP   = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up,
    input  logic              down,
    output logic [GAIN_W-1:0] gain,
    output logic              at_zero,
    output logic              at_unity
);

    localparam logic [GAIN_W:0] UNITY  = (GAIN_W+1)'(1) << (GAIN_W - 1);
    // A step at or above unity collapses to a one-frame ramp.
    localparam logic [GAIN_W:0] STEP_C = (STEP >= (1 << (GAIN_W - 1))) ? UNITY : (GAIN_W+1)'(STEP);

    logic [GAIN_W-1:0] gain_reg;
    logic [GAIN_W-1:0] gain_next;
    logic [GAIN_W:0]   gain_ext;
    logic [GAIN_W:0]   sum;
    logic [GAIN_W:0]   diff;

    always_comb begin
        gain_ext  = {1'b0, gain_reg};
        sum       = gain_ext + STEP_C;
        diff      = gain_ext - STEP_C;
        gain_next = gain_reg;
        if (up) begin
            gain_next = (sum >= UNITY) ? UNITY[GAIN_W-1:0] : sum[GAIN_W-1:0];
        end else if (down) begin
            gain_next = (gain_ext <= STEP_C) ? '0 : diff[GAIN_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gain_reg <= '0;
        end else begin
            gain_reg <= gain_next;
        end
    end

    assign gain     = gain_reg;
    assign at_zero  = (gain_reg == '0);
    assign at_unity = ({1'b0, gain_reg} == UNITY);

endmodule

// File: rtl/audio_src_switch_ctrl.sv
// Click-free source-switch sequencer: fade out, flush mux, switch, settle muted, fade in.
// Define AUDIO_SWITCH_TIMEOUT_EN to force a step after TIMEOUT_CYCLES without a frame tick.
module audio_src_switch_ctrl
    import audio_pkg::*;
#(
    parameter int         GAIN_W         = GAIN_W_DEF,
    parameter int         STEP           = 256,
    parameter int         SETTLE_FRAMES  = 8,
    parameter logic [1:0] INIT_SELECT    = SRC_I2S,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_select,
    input  logic              req_strobe,
    input  logic              frame_tick,
    output logic [1:0]        mux_select,
    output logic              mux_run,
    output logic [GAIN_W-1:0] gain,
    output logic              busy,
    output logic              switch_done
);

    localparam int CNT_W = $clog2(SETTLE_FRAMES + 1);

    state_t            state_reg;
    state_t            state_next;
    logic [1:0]        sel_reg;
    logic [1:0]        pend_sel_reg;
    logic              pending_reg;
    logic [CNT_W-1:0]  settle_cnt_reg;

    logic tick;
    logic redirect;
    logic ramp_up;
    logic ramp_down;
    logic flush;
    logic done;
    logic at_zero;
    logic at_unity;

    always_comb begin
        assert (STEP > 0 && SETTLE_FRAMES >= 1 && TIMEOUT_CYCLES >= 2);
    end

`ifdef AUDIO_SWITCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_reg;
    logic            to_fire;

    assign to_fire = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
    assign tick    = frame_tick | to_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_reg <= '0;
        end else if (frame_tick || to_fire || (state_next != state_reg)) begin
            to_cnt_reg <= '0;
        end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end
`else
    assign tick = frame_tick;
`endif

    assign redirect = pending_reg && (pend_sel_reg != sel_reg);

    always_comb begin
        state_next = state_reg;
        ramp_up    = 1'b0;
        ramp_down  = 1'b0;
        flush      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (redirect) state_next = FADE_OUT;
            end
            FADE_OUT: begin
                if (at_zero) state_next = FLUSH;
                else         ramp_down  = tick;
            end
            FLUSH: begin
                flush      = 1'b1;
                state_next = SETTLE;
            end
            SETTLE: begin
                // Gain is already zero, so a differing request can re-flush immediately.
                if (redirect)                 state_next = FLUSH;
                else if (settle_cnt_reg == '0) state_next = FADE_IN;
            end
            FADE_IN: begin
                if (redirect) begin
                    state_next = FADE_OUT;
                end else if (at_unity) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end else begin
                    ramp_up = tick;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= FADE_IN;
            sel_reg        <= INIT_SELECT;
            pend_sel_reg   <= INIT_SELECT;
            pending_reg    <= 1'b0;
            settle_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (flush) sel_reg <= pend_sel_reg;

            // Last request wins; in IDLE a request for the current source is dropped.
            if (req_strobe) begin
                pend_sel_reg <= req_select;
                pending_reg  <= !((state_reg == IDLE) && (req_select == sel_reg));
            end else if (flush || ((state_reg == IDLE) && !redirect)) begin
                pending_reg <= 1'b0;
            end

            if (flush) begin
                settle_cnt_reg <= CNT_W'(SETTLE_FRAMES);
            end else if ((state_reg == SETTLE) && tick && (settle_cnt_reg != '0)) begin
                settle_cnt_reg <= settle_cnt_reg - 1'b1;
            end
        end
    end

    gain_ramp #(
        .GAIN_W (GAIN_W),
        .STEP   (STEP)
    ) u_gain_ramp (
        .clk      (clk),
        .reset    (reset),
        .up       (ramp_up),
        .down     (ramp_down),
        .gain     (gain),
        .at_zero  (at_zero),
        .at_unity (at_unity)
    );

    assign mux_select  = sel_reg;
    assign mux_run     = (state_reg != FLUSH);
    assign busy        = (state_reg != IDLE);
    assign switch_done = done;

endmodule
